// File: rtl/krv_pwm_pkg.sv
// krv_pwm_pkg: register map, channel state encoding and duty stepping shared by pwm_ramp_ctrl.
package krv_pwm_pkg;

    localparam int DUTY_W = 8;

    localparam logic [2:0] REG_EN   = 3'd0;
    localparam logic [2:0] REG_TGT1 = 3'd1;
    localparam logic [2:0] REG_TGT2 = 3'd2;
    localparam logic [2:0] REG_TGT3 = 3'd3;
    localparam logic [2:0] REG_TGT4 = 3'd4;
    localparam logic [2:0] REG_DIV  = 3'd5;
    localparam logic [2:0] REG_STAT = 3'd6;

    typedef enum logic [1:0] {OFF, RAMP, HOLD, STOP} ch_state_e;

    // One LSB toward tgt; never overshoots, so it cannot wrap.
    function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                      input logic [DUTY_W-1:0] tgt);
        return cur < tgt ? cur + 1'b1 : cur > tgt ? cur - 1'b1 : cur;
    endfunction

endpackage

// File: rtl/pwm_ramp_channel.sv
// pwm_ramp_channel: per-channel soft-ramp FSM and duty register; only built when PWM_RAMP_EN is defined.
`ifdef PWM_RAMP_EN
module pwm_ramp_channel
    import krv_pwm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              en,
    input  logic [DUTY_W-1:0] target,
    output logic [DUTY_W-1:0] duty,
    output logic              enable,
    output logic              busy
);

    ch_state_e         state_q;
    logic [DUTY_W-1:0] cur_q;
    logic              enable_q;
    logic              busy_q;
    logic [DUTY_W-1:0] ramp_d;
    logic [DUTY_W-1:0] stop_d;

    assign ramp_d = tick ? step_toward(cur_q, target) : cur_q;
    assign stop_d = (tick && cur_q != '0) ? cur_q - 1'b1 : cur_q;

    // Exit decisions look at the post-step value so HOLD/OFF land on the edge the target/zero is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= OFF;
            cur_q    <= '0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                OFF: if (en) begin
                    state_q  <= RAMP;
                    enable_q <= 1'b1;
                    busy_q   <= 1'b1;
                end
                RAMP: begin
                    cur_q <= ramp_d;
                    if (!en) state_q <= STOP;
                    else if (ramp_d == target) begin
                        state_q <= HOLD;
                        busy_q  <= 1'b0;
                    end
                end
                HOLD: if (!en) begin
                    state_q <= STOP;
                    busy_q  <= 1'b1;
                end else if (target != cur_q) begin
                    state_q <= RAMP;
                    busy_q  <= 1'b1;
                end
                STOP: begin
                    cur_q <= stop_d;
                    if (en) state_q <= RAMP;
                    else if (stop_d == '0) begin
                        state_q  <= OFF;
                        enable_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign duty   = cur_q;
    assign enable = enable_q;
    assign busy   = busy_q;

endmodule
`endif

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: register front end for the 4-channel PWM block.
// PWM_RAMP_EN defined adds the prescaler and soft-ramp channels; otherwise duty follows TARGET & EN directly.
module pwm_ramp_ctrl
    import krv_pwm_pkg::*;
#(
    parameter int DIV_W     = 20,
    parameter int RESET_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [2:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [3:0]        enable,
    output logic [DUTY_W-1:0] duty_cycle_ch1,
    output logic [DUTY_W-1:0] duty_cycle_ch2,
    output logic [DUTY_W-1:0] duty_cycle_ch3,
    output logic [DUTY_W-1:0] duty_cycle_ch4,
    output logic [3:0]        busy
);

    logic [3:0]        en_q;
    logic [DUTY_W-1:0] tgt_q [4];
    logic [DIV_W-1:0]  div_q;
    logic [31:0]       rdata_q;
    logic [31:0]       rdata_d;
    logic [DUTY_W-1:0] duty [4];
    logic              unused_wdata;

    assign unused_wdata = ^wdata[31:DIV_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q    <= '0;
            div_q   <= DIV_W'(RESET_DIV);
            rdata_q <= '0;
            for (int i = 0; i < 4; i++) tgt_q[i] <= '0;
        end else begin
            if (re) rdata_q <= rdata_d;
            if (we && addr == REG_EN) en_q <= wdata[3:0];
            if (we && addr == REG_DIV) div_q <= wdata[DIV_W-1:0];
            for (int i = 0; i < 4; i++)
                if (we && addr == REG_TGT1 + 3'(i)) tgt_q[i] <= wdata[DUTY_W-1:0];
        end
    end

    always_comb begin
        rdata_d = '0;
        if (addr == REG_EN) rdata_d[3:0] = en_q;
        if (addr == REG_DIV) rdata_d[DIV_W-1:0] = div_q;
        if (addr == REG_STAT) rdata_d[3:0] = busy;
        for (int i = 0; i < 4; i++)
            if (addr == REG_TGT1 + 3'(i)) rdata_d[DUTY_W-1:0] = tgt_q[i];
    end

`ifdef PWM_RAMP_EN
    logic [DIV_W-1:0] cnt_q;
    logic             tick;

    assign tick = cnt_q == div_q;

    // Rewriting STEP_DIV restarts the tick period from zero.
    always_ff @(posedge clk) begin
        if (rst || (we && addr == REG_DIV)) cnt_q <= '0;
        else cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end

    for (genvar g = 0; g < 4; g++) begin : g_ch
        pwm_ramp_channel u_ch (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .en    (en_q[g]),
            .target(tgt_q[g]),
            .duty  (duty[g]),
            .enable(enable[g]),
            .busy  (busy[g])
        );
    end
`else
    logic [3:0]        enable_q;
    logic [DUTY_W-1:0] duty_q [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q <= '0;
            for (int i = 0; i < 4; i++) duty_q[i] <= '0;
        end else begin
            enable_q <= en_q;
            for (int i = 0; i < 4; i++) duty_q[i] <= tgt_q[i] & {DUTY_W{en_q[i]}};
        end
    end

    assign enable = enable_q;
    assign duty   = duty_q;
    assign busy   = '0;
`endif

    assign rdata          = rdata_q;
    assign duty_cycle_ch1 = duty[0];
    assign duty_cycle_ch2 = duty[1];
    assign duty_cycle_ch3 = duty[2];
    assign duty_cycle_ch4 = duty[3];

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Bus-mapped control front end for the 4-channel PWM generator of KRV-32. It accepts register writes from the core, holds per-channel target duty cycles and channel enables, and drives the PWM block's `duty_cycle_chN` and `enable` inputs. Duty changes are soft-ramped, one LSB per prescaled tick. A disabled channel ramps down to 0 before its enable output drops.

## Interface
- `DIV_W`, 20: prescaler / STEP_DIV width.
- `RESET_DIV`, 1000: STEP_DIV value after reset.
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `we`  in  1  register write strobe, one cycle
- `re`  in  1  register read strobe, one cycle
- `addr`  in  3  word index into the register map
- `wdata`  in  32  write data
- `rdata`  out  32  read data, registered
- `enable`  out  4  channel enables to the PWM block
- `duty_cycle_ch1`..`duty_cycle_ch4`  out  8 each  current ramped duty to the PWM block
- `busy`  out  4  channel N is not in OFF or HOLD

## Operation
- Register map (addr):
  - 0: EN[3:0], R/W.
  - 1–4: TARGET_CH1..4[7:0], R/W.
  - 5: STEP_DIV[DIV_W-1:0], R/W.
  - 6: STATUS, RO. [3:0] = busy, [11:4] unused = 0.
  - 7: reads 0, writes ignored.
  - Unused high bits read 0.
- Prescaler:
  - Counts 0..STEP_DIV; `tick` pulses for one cycle when count == STEP_DIV, then the count wraps to 0.
  - STEP_DIV = 0 means tick every cycle.
  - A write to STEP_DIV clears the count.
- Per-channel FSM (states OFF, RAMP, HOLD, STOP; `cur` = current duty):
  - OFF: `cur` = 0, `enable[N]` = 0. EN[N] = 1 → RAMP, and `enable[N]` = 1 from the next cycle.
  - RAMP: on tick, `cur` moves 1 toward TARGET. When `cur` == TARGET → HOLD; this includes entry with `cur` == TARGET, with no tick needed. EN[N] = 0 → STOP.
  - HOLD: TARGET != `cur` → RAMP. EN[N] = 0 → STOP.
  - STOP: on tick, `cur` decrements. When `cur` == 0 → OFF and `enable[N]` clears in the same transition. EN[N] = 1 → RAMP.
- Arithmetic: `cur` saturates at 0 and 255 and never wraps. Only one step per tick, regardless of the distance to TARGET.
- Simultaneous events:
  - `we` and `re` to the same address in the same cycle: `rdata` returns the old value.
  - A register write takes effect on FSM decisions one cycle after `we`.
  - A tick coinciding with a state change applies the step of the state being left.
- `re` and `we` have no handshake; they are always accepted.

## Timing
- Reset values:
  - `rdata` = 0, `enable` = 0, all duty outputs = 0, `busy` = 0.
  - EN = 0, TARGETs = 0, STEP_DIV = RESET_DIV, prescaler = 0, all FSMs = OFF.
- Read latency: `rdata` is valid in the cycle after `re` and holds until the next `re`.
- Write latency: register updated at the `we` edge. `enable[N]` rises 2 cycles after the `we` that sets EN[N].
- Ramp time from 0 to D: D × (STEP_DIV+1) cycles, ±(STEP_DIV+1).
- `rst` mid-ramp: all outputs return to reset values in the next cycle; no ramp-down.

## Configuration
- `PWM_RAMP_EN` defined: behaviour as above.
- `PWM_RAMP_EN` undefined:
  - Prescaler and FSMs are removed.
  - `duty_cycle_chN` = TARGET_CHN & {8{EN[N]}}, registered, 1 cycle after the write.
  - `enable` = EN, registered.
  - `busy` = 0; STATUS reads 0.
  - STEP_DIV stays readable and writable but has no effect.

## Structure
- Package `krv_pwm_pkg`:
  - Register index constants (REG_EN, REG_TGT1..4, REG_DIV, REG_STAT).
  - Channel state enum (OFF/RAMP/HOLD/STOP).
  - Duty width constant (8).
- Sub-module `pwm_ramp_channel`:
  - One FSM plus `cur` register.
  - Inputs: `clk`, `rst`, `tick`, `en`, `target`.
  - Outputs: `duty`, `enable`, `busy`.
  - Instantiated 4×.
- Top level holds the register file, prescaler and read mux.

## Test plan
- Reset then read addr 0–7 → 0,0,0,0,0,RESET_DIV,0,0; all outputs 0.
- STEP_DIV=3, TARGET_CH1=10, EN=0x1 → `enable[0]` rises 2 cycles after write; `duty_cycle_ch1` reaches 10 after 40±4 cycles; `busy[0]` then 0.
- Channel 2 holding 200, write TARGET_CH2=190 → duty steps down 1 per tick to 190, then HOLD.
- Channel 3 at 5, clear EN[2] → duty 5→0 over 5 ticks, then `enable[2]` clears on the same edge as duty reaches 0. Re-set EN[2] mid-STOP → ramp resumes upward from the current value.
- STEP_DIV=0, TARGET_CH4=255 → duty increments every cycle and stops at 255, no wrap. Assert `rst` at duty 128 → all outputs 0 next cycle.
- With `PWM_RAMP_EN` undefined: TARGET_CH1=77, EN=1 → `duty_cycle_ch1`=77 one cycle after the EN write; STATUS reads 0.
